ym_hsync_gen: RTL and testbench

Horizontal timing generator for the video side of the bus-arbiter/clock pair. It counts rising edges of the arbiter's EDCLK output and produces the active-low HSYNC that the arbiter uses to resynchronise EDCLK, plus a pixel counter, an HBLANK flag and a line-start pulse. It runs entirely in the MCLK domain and treats EDCLK as a sampled level. It supports the H32 (256-pixel) and H40 (320-pixel) line formats.

---
 rtl/ym_hsync_pkg.sv | 44 ++++
 rtl/ym_hsync_gen_if.sv | 22 ++
 rtl/ym_hsync_edge.sv | 23 ++
 rtl/ym_hsync_gen.sv | 111 +++++++++++
 tb/tb_ym_hsync_gen.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ym_hsync_pkg.sv
// Shared line-format constants, mode encoding and per-mode timing lookup for ym_hsync_gen.
package ym_hsync_pkg;

    localparam int unsigned DEF_H32_LEN        = 342;
    localparam int unsigned DEF_H40_LEN        = 420;
    localparam int unsigned DEF_H32_ACTIVE     = 256;
    localparam int unsigned DEF_H40_ACTIVE     = 320;
    localparam int unsigned DEF_H32_SYNC_START = 280;
    localparam int unsigned DEF_H40_SYNC_START = 346;
    localparam int unsigned DEF_SYNC_LEN       = 26;

    typedef enum logic {
        MODE_H32 = 1'b0,
        MODE_H40 = 1'b1
    } mode_e;

    // len is 10 bits so a full 512-pixel line is representable
    typedef struct packed {
        logic [9:0] len;
        logic [8:0] active;
        logic [8:0] sync_start;
    } line_timing_t;

    localparam line_timing_t H32_TIMING = '{
        len:        10'(DEF_H32_LEN),
        active:     9'(DEF_H32_ACTIVE),
        sync_start: 9'(DEF_H32_SYNC_START)
    };

    localparam line_timing_t H40_TIMING = '{
        len:        10'(DEF_H40_LEN),
        active:     9'(DEF_H40_ACTIVE),
        sync_start: 9'(DEF_H40_SYNC_START)
    };

    function automatic line_timing_t mode_timing(
        input mode_e        m,
        input line_timing_t h32 = H32_TIMING,
        input line_timing_t h40 = H40_TIMING
    );
        return (m == MODE_H40) ? h40 : h32;
    endfunction

endpackage

// File: rtl/ym_hsync_gen_if.sv
// Video-side bus of ym_hsync_gen: pixel clock and format request in, sync/blank/counter out.
interface ym_hsync_gen_if;

    logic       EDCLK;
    logic       H40;
    logic       en;
    logic       HSYNC;
    logic       HBLANK;
    logic       line_start;
    logic [8:0] hcnt;

    modport master (
        output EDCLK, H40, en,
        input  HSYNC, HBLANK, line_start, hcnt
    );

    modport slave (
        input  EDCLK, H40, en,
        output HSYNC, HBLANK, line_start, hcnt
    );

endinterface

// File: rtl/ym_hsync_edge.sv
// EDCLK sampler and enable-gated rising-edge detector; tick is one MCLK wide.
module ym_hsync_edge (
    input  logic MCLK,
    input  logic reset,
    input  logic EDCLK,
    input  logic en,
    output logic tick
);

    logic edclk_q;

    // Keeps tracking EDCLK while en is low, so an edge during en=0 is dropped
    always_ff @(posedge MCLK) begin
        if (reset) begin
            edclk_q <= 1'b0;
        end else begin
            edclk_q <= EDCLK;
        end
    end

    assign tick = EDCLK & ~edclk_q & en;

endmodule

// File: rtl/ym_hsync_gen.sv
// Horizontal timing generator (H32/H40) clocked by MCLK, stepping on EDCLK rising edges.
// Optional HBLANK output enabled by defining YM_HSYNC_HBLANK_EN; otherwise HBLANK is tied low.
module ym_hsync_gen
    import ym_hsync_pkg::*;
#(
    parameter int unsigned H32_LEN        = DEF_H32_LEN,
    parameter int unsigned H40_LEN        = DEF_H40_LEN,
    parameter int unsigned H32_ACTIVE     = DEF_H32_ACTIVE,
    parameter int unsigned H40_ACTIVE     = DEF_H40_ACTIVE,
    parameter int unsigned H32_SYNC_START = DEF_H32_SYNC_START,
    parameter int unsigned H40_SYNC_START = DEF_H40_SYNC_START,
    parameter int unsigned SYNC_LEN       = DEF_SYNC_LEN
) (
    input  logic           MCLK,
    input  logic           reset,
    ym_hsync_gen_if.slave  bus
);

    if ((H32_LEN > 512) || (H40_LEN > 512) || (H32_LEN == 0) || (H40_LEN == 0)) begin : g_len_check
        $error("ym_hsync_gen: line length must be in 1..512");
    end

    localparam line_timing_t T32 = '{
        len:        10'(H32_LEN),
        active:     9'(H32_ACTIVE),
        sync_start: 9'(H32_SYNC_START)
    };

    localparam line_timing_t T40 = '{
        len:        10'(H40_LEN),
        active:     9'(H40_ACTIVE),
        sync_start: 9'(H40_SYNC_START)
    };

    localparam logic [8:0] SYNC_W = 9'(SYNC_LEN);

    logic         tick;
    mode_e        mode_q;
    mode_e        mode_nx;
    logic [8:0]   hcnt_q;
    logic [8:0]   hcnt_nx;
    logic [8:0]   last_pix;
    logic         wrap;
    logic         hsync_q;
    logic         hsync_nx;
    logic         line_start_q;
    line_timing_t cur;

    ym_hsync_edge u_edge (
        .MCLK  (MCLK),
        .reset (reset),
        .EDCLK (bus.EDCLK),
        .en    (bus.en),
        .tick  (tick)
    );

    // Decoding the next count against the current mode is safe across a wrap:
    // the next count is then 0, which lies outside sync/blank in either mode.
    always_comb begin
        cur      = mode_timing(mode_q, T32, T40);
        last_pix = 9'(cur.len - 10'd1);
        wrap     = tick && (hcnt_q == last_pix);
        mode_nx  = mode_q;
        hcnt_nx  = hcnt_q + 9'd1;
        if (wrap) begin
            hcnt_nx = '0;
            mode_nx = mode_e'(bus.H40);
        end
        hsync_nx = !((hcnt_nx >= cur.sync_start) && (hcnt_nx < cur.sync_start + SYNC_W));
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            mode_q       <= mode_e'(bus.H40);
            hcnt_q       <= '0;
            hsync_q      <= 1'b1;
            line_start_q <= 1'b0;
        end else begin
            line_start_q <= wrap;
            if (tick) begin
                mode_q  <= mode_nx;
                hcnt_q  <= hcnt_nx;
                hsync_q <= hsync_nx;
            end
        end
    end

`ifdef YM_HSYNC_HBLANK_EN
    logic hblank_q;

    always_ff @(posedge MCLK) begin
        if (reset) begin
            hblank_q <= 1'b0;
        end else if (tick) begin
            hblank_q <= (hcnt_nx >= cur.active);
        end
    end

    assign bus.HBLANK = hblank_q;
`else
    logic unused_active;

    assign unused_active = ^cur.active;
    assign bus.HBLANK    = 1'b0;
`endif

    assign bus.HSYNC      = hsync_q;
    assign bus.line_start = line_start_q;
    assign bus.hcnt       = hcnt_q;

endmodule

// File: tb/tb_ym_hsync_gen.sv
// Bench for ym_hsync_gen: directed line-format scenarios plus randomized EDCLK/en/H40/reset.
module tb_ym_hsync_gen;

    logic MCLK = 1'b0;
    logic reset;

    ym_hsync_gen_if bus ();

    ym_hsync_gen #(
        .H32_LEN        (342),
        .H40_LEN        (420),
        .H32_ACTIVE     (256),
        .H40_ACTIVE     (320),
        .H32_SYNC_START (280),
        .H40_SYNC_START (346),
        .SYNC_LEN       (26)
    ) dut (
        .MCLK  (MCLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: pixel index per line, mode latched at line wrap
    int m_cnt;
    bit m_h40;
    bit m_prev;
    bit m_ls;
    bit m_valid = 1'b0;

    function automatic int line_len(bit h40);
        return h40 ? 420 : 342;
    endfunction

    function automatic bit exp_hsync(int cnt, bit h40);
        int ss;
        ss = h40 ? 346 : 280;
        return !(cnt >= ss && cnt < ss + 26);
    endfunction

    function automatic bit exp_hblank(int cnt, bit h40);
`ifdef YM_HSYNC_HBLANK_EN
        return cnt >= (h40 ? 320 : 256);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge MCLK) begin
        bit tick;
        if (reset) begin
            m_cnt   = 0;
            m_h40   = bus.H40;
            m_prev  = 1'b0;
            m_ls    = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            tick   = bus.EDCLK && !m_prev && bus.en;
            m_prev = bus.EDCLK;
            m_ls   = 1'b0;
            if (tick) begin
                if (m_cnt == line_len(m_h40) - 1) begin
                    m_cnt = 0;
                    m_h40 = bus.H40;
                    m_ls  = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge MCLK) begin
        if (m_valid) begin
            chk("hcnt",       32'(bus.hcnt),       32'(m_cnt));
            chk("HSYNC",      32'(bus.HSYNC),      32'(exp_hsync(m_cnt, m_h40)));
            chk("HBLANK",     32'(bus.HBLANK),     32'(exp_hblank(m_cnt, m_h40)));
            chk("line_start", 32'(bus.line_start), 32'(m_ls));
        end
    end

    int ed_mode = 0;

    task automatic cyc();
        @(posedge MCLK);
        #1;
        if (ed_mode == 0) bus.EDCLK = ~bus.EDCLK;
        else              bus.EDCLK = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset(input bit h40);
        reset   = 1'b1;
        bus.H40 = h40;
        bus.en  = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
    endtask

    task automatic wait_hcnt(input int val, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.hcnt == 9'(val)) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic wait_ls(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (bus.line_start) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, 32'(found), 32'd1);
    endtask

    // Starts on a line_start cycle; gathers statistics up to the next line_start
    task automatic measure(output int period, output int low, output int mx,
                           output int flow, output int llow,
                           output int bfirst, output int bcyc);
        period = 0; low = 0; mx = 0; flow = -1; llow = -1; bfirst = -1; bcyc = 0;
        do begin
            if (!bus.HSYNC) begin
                low++;
                if (flow < 0) flow = int'(bus.hcnt);
                llow = int'(bus.hcnt);
            end
            if (bus.HBLANK) begin
                bcyc++;
                if (bfirst < 0) bfirst = int'(bus.hcnt);
            end
            if (int'(bus.hcnt) > mx) mx = int'(bus.hcnt);
            cyc();
            period++;
        end while (!bus.line_start && period < 3000);
    endtask

    task automatic check_line(input string tag, input bit h40);
        int period, low, mx, flow, llow, bfirst, bcyc;
        measure(period, low, mx, flow, llow, bfirst, bcyc);
        chk({tag, "_period"},    32'(period), h40 ? 32'd840 : 32'd684);
        chk({tag, "_sync_mclk"}, 32'(low),    32'd52);
        chk({tag, "_max_hcnt"},  32'(mx),     h40 ? 32'd419 : 32'd341);
        chk({tag, "_sync_first"},32'(flow),   h40 ? 32'd346 : 32'd280);
        chk({tag, "_sync_last"}, 32'(llow),   h40 ? 32'd371 : 32'd305);
`ifdef YM_HSYNC_HBLANK_EN
        chk({tag, "_blank_first"}, 32'(bfirst), h40 ? 32'd320 : 32'd256);
        chk({tag, "_blank_mclk"},  32'(bcyc),   h40 ? 32'd200 : 32'd172);
`else
        chk({tag, "_blank_mclk"},  32'(bcyc),   32'd0);
`endif
    endtask

    initial begin
        int mx;
        int n;
        reset     = 1'b1;
        bus.EDCLK = 1'b0;
        bus.en    = 1'b1;
        bus.H40   = 1'b0;

        // H32 line timing
        do_reset(1'b0);
        chk("rst_hcnt",  32'(bus.hcnt),       32'd0);
        chk("rst_hsync", 32'(bus.HSYNC),      32'd1);
        chk("rst_blank", 32'(bus.HBLANK),     32'd0);
        chk("rst_ls",    32'(bus.line_start), 32'd0);
        wait_ls("h32_first_wrap");
        check_line("h32_a", 1'b0);
        check_line("h32_b", 1'b0);

        // H40 line timing
        do_reset(1'b1);
        wait_ls("h40_first_wrap");
        check_line("h40", 1'b1);

        // H40 request mid-line only takes effect after the wrap
        do_reset(1'b0);
        wait_ls("sw_first_wrap");
        wait_hcnt(100, "sw_reach_100");
        bus.H40 = 1'b1;
        mx = 0;
        n  = 0;
        while (!bus.line_start && n < 3000) begin
            if (int'(bus.hcnt) > mx) mx = int'(bus.hcnt);
            cyc();
            n++;
        end
        chk("sw_cur_line_max", 32'(mx), 32'd341);
        check_line("sw_next", 1'b1);

        // Reset during HSYNC low
        do_reset(1'b0);
        wait_hcnt(300, "rs_reach_300");
        chk("rs_hsync_low", 32'(bus.HSYNC), 32'd0);
        reset = 1'b1;
        cyc();
        chk("rs_hcnt",  32'(bus.hcnt),       32'd0);
        chk("rs_hsync", 32'(bus.HSYNC),      32'd1);
        chk("rs_blank", 32'(bus.HBLANK),     32'd0);
        chk("rs_ls",    32'(bus.line_start), 32'd0);
        reset = 1'b0;
        n = 0;
        while (bus.hcnt == 9'd0 && n < 20) begin
            cyc();
            n++;
        end
        chk("rs_next_tick", 32'(bus.hcnt), 32'd1);

        // en low for 10 MCLK freezes the count
        wait_hcnt(50, "en_reach_50");
        bus.en = 1'b0;
        repeat (10) cyc();
        chk("en_hold", 32'(bus.hcnt), 32'd50);
        bus.en = 1'b1;
        n = 0;
        while (bus.hcnt == 9'd50 && n < 20) begin
            cyc();
            n++;
        end
        chk("en_resume", 32'(bus.hcnt), 32'd51);

        // Randomized EDCLK, en, format requests and occasional resets
        ed_mode = 1;
        for (int i = 0; i < 20000; i++) begin
            cyc();
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) bus.H40 = ~bus.H40;
            reset = ($urandom_range(0, 2999) == 0);
        end
        reset = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
